gerenciador_de_pc: RTL and testbench

GERENCIADOR_DE_PC -- requirements
Module: gerenciador_de_pc

---
 rtl/gerenciador_de_pc_pkg.sv | 18 +
 rtl/gerenciador_de_pc_pilha_de_retorno.sv | 57 +++++
 rtl/gerenciador_de_pc.sv | 119 +++++++++++
 tb/tb_gerenciador_de_pc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_de_pc_pkg.sv
// Shared encodings for the PC manager: next-PC source select, run/halt state,
// and default reset/exception vectors.
package gerenciador_de_pc_pkg;

  localparam int unsigned ADDR_W_DEF = 26;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_RETURN = 2'd3;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  localparam logic [25:0] RESET_VEC_DEF = 26'h0000000;
  localparam logic [25:0] EXC_VEC_DEF   = 26'h0000020;

endpackage

// File: rtl/gerenciador_de_pc_pilha_de_retorno.sv
// Return-address stack as a circular buffer; a push when full overwrites the oldest
// entry. Pointer/count update on the clock edge, top entry is read combinationally.
module pilha_de_retorno #(
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic              clock_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] dat_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, top_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);
  assign top_idx = wp_q - PTR_W'(1);
  assign top_o   = mem[top_idx];

  // When full, wp_q already points at the oldest entry, so a push overwrites it.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      wp_d = wp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      wp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_i) mem[wp_q] <= dat_i;
  end

endmodule

// File: rtl/gerenciador_de_pc.sv
// Program-counter manager: sequential/branch/jump/return next-PC, exceptions with EPC,
// halt state and a return-address stack. All outputs update one cycle after sampling.
module gerenciador_de_pc
  import gerenciador_de_pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic              clock,
  input  logic              pc_reset,
  input  logic              enable,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic              exception,
  input  logic              eret,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pcAtual,
  output logic [ADDR_W-1:0] epc,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc, ras_top;
  logic              state_q, state_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ras_push, ras_pop;

  assign pc_inc = pc_q + ADDR_W'(1);

  pilha_de_retorno #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock_i(clock),
    .rst_n_i(pc_reset),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .dat_i  (pc_inc),
    .top_o  (ras_top),
    .empty_o(ras_empty),
    .full_o (ras_full)
  );

  // Priority: exception, then halt hold, then stall, then eret, halt request, sel.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    state_d  = state_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (exception) begin
      pc_d    = EXC_VEC;
      epc_d   = pc_q;
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      if (resume) state_d = ST_RUN;
    end else if (enable) begin
      if (eret) begin
        pc_d = epc_q;
      end else if (halt) begin
        state_d = ST_HALT;
      end else begin
        case (sel)
          SEL_BRANCH: pc_d = branch_target;
          SEL_JUMP: begin
            pc_d = jump_target;
            if (call) begin
              ras_push = 1'b1;
              if (ras_full) ovf_d = 1'b1;
            end
          end
          SEL_RETURN: begin
            if (!ras_empty) begin
              pc_d    = ras_top;
              ras_pop = 1'b1;
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge pc_reset) begin
    if (!pc_reset) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pcAtual       = pc_q;
  assign epc           = epc_q;
  assign halted        = (state_q == ST_HALT);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_gerenciador_de_pc.sv
// Bench for gerenciador_de_pc: directed vector table plus randomized run against
// a queue-based reference model.
module tb_gerenciador_de_pc;
  import gerenciador_de_pc_pkg::*;

  localparam int AW = 26;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          pc_reset, enable, call, exception, eret, halt, resume;
  logic [1:0]    sel;
  logic [AW-1:0] branch_target, jump_target;
  logic [AW-1:0] pcAtual, epc;
  logic          halted, ras_empty, ras_full, ras_overflow, ras_underflow;

  always #5 clock = ~clock;

  gerenciador_de_pc dut (
    .clock(clock), .pc_reset(pc_reset), .enable(enable), .sel(sel),
    .branch_target(branch_target), .jump_target(jump_target), .call(call),
    .exception(exception), .eret(eret), .halt(halt), .resume(resume),
    .pcAtual(pcAtual), .epc(epc), .halted(halted), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  typedef struct {
    logic          en;
    logic [1:0]    sel;
    logic [AW-1:0] bt, jt;
    logic          call, exc, eret, halt, resume;
    logic [AW-1:0] e_pc, e_epc;
    logic          e_h, e_em, e_fu, e_ov, e_un;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  // Reference model state
  logic [AW-1:0] m_pc, m_epc;
  logic          m_halt, m_ovf, m_unf;
  logic [AW-1:0] stk[$];

  function automatic vec_t mk(input logic en, input logic [1:0] s, input logic [AW-1:0] tgt,
                              input logic c, x, r, h, rs, input logic [AW-1:0] ep, ee,
                              input logic eh, eem, efu, eov, eun);
    vec_t v;
    v.en = en; v.sel = s; v.bt = tgt; v.jt = tgt; v.call = c; v.exc = x; v.eret = r;
    v.halt = h; v.resume = rs; v.e_pc = ep; v.e_epc = ee; v.e_h = eh; v.e_em = eem;
    v.e_fu = efu; v.e_ov = eov; v.e_un = eun;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [AW-1:0] e_pc, e_epc,
                           input logic e_h, e_em, e_fu, e_ov, e_un);
    chk({tag, ".pc"}, pcAtual, e_pc);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".halted"}, AW'(halted), AW'(e_h));
    chk({tag, ".empty"}, AW'(ras_empty), AW'(e_em));
    chk({tag, ".full"}, AW'(ras_full), AW'(e_fu));
    chk({tag, ".ovf"}, AW'(ras_overflow), AW'(e_ov));
    chk({tag, ".unf"}, AW'(ras_underflow), AW'(e_un));
  endtask

  task automatic drive(input vec_t v);
    enable = v.en; sel = v.sel; branch_target = v.bt; jump_target = v.jt;
    call = v.call; exception = v.exc; eret = v.eret; halt = v.halt; resume = v.resume;
  endtask

  task automatic model_reset();
    m_pc = '0; m_epc = '0; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    stk.delete();
  endtask

  task automatic model_step(input vec_t v);
    if (v.exc) begin
      m_epc  = m_pc;
      m_pc   = 26'h20;
      m_halt = 1'b0;
    end else if (m_halt) begin
      if (v.resume) m_halt = 1'b0;
    end else if (v.en) begin
      if (v.eret) m_pc = m_epc;
      else if (v.halt) m_halt = 1'b1;
      else if (v.sel == 2'd0) m_pc = AW'(m_pc + 1);
      else if (v.sel == 2'd1) m_pc = v.bt;
      else if (v.sel == 2'd2) begin
        if (v.call) begin
          if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            m_ovf = 1'b1;
          end
          stk.push_back(AW'(m_pc + 1));
        end
        m_pc = v.jt;
      end else begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else begin
          m_pc  = AW'(m_pc + 1);
          m_unf = 1'b1;
        end
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk(0, SEL_SEQ, '0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
    v.en     = ($urandom_range(0, 3) != 0);
    v.sel    = 2'($urandom_range(0, 3));
    v.bt     = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom);
    v.jt     = AW'($urandom);
    v.call   = 1'($urandom_range(0, 1));
    v.exc    = ($urandom_range(0, 24) == 0);
    v.eret   = ($urandom_range(0, 11) == 0);
    v.halt   = ($urandom_range(0, 14) == 0);
    v.resume = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  initial begin
    vec_t v;
    drive(mk(1, SEL_SEQ, '0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    pc_reset = 1'b0;
    #12;
    check_all("reset", '0, '0, 0, 1, 0, 0, 0);
    pc_reset = 1'b1;

    // Asynchronous reset at pc=0x55 with a pending call discards it
    drive(mk(1, SEL_BRANCH, 26'h55, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    chk("pre_rst.pc", pcAtual, 26'h55);
    drive(mk(1, SEL_JUMP, 26'h777, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    pc_reset = 1'b0;
    #2;
    check_all("arst", '0, '0, 0, 1, 0, 0, 0);
    @(posedge clock); #1;
    check_all("arst_hold", '0, '0, 0, 1, 0, 0, 0);
    @(negedge clock);
    drive(mk(1, SEL_SEQ, '0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0));
    pc_reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      check_all($sformatf("seq%0d", i), AW'(i), '0, 0, 1, 0, 0, 0);
    end

    // Directed table, continuing from pc=3
    tbl.push_back(mk(1, SEL_BRANCH, 26'h3FFFFFF, 0, 0, 0, 0, 0, 26'h3FFFFFF, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_SEQ,    '0,          0, 0, 0, 0, 0, 26'h0,       0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_BRANCH, 26'h100,     0, 0, 0, 0, 0, 26'h100,     0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_BRANCH, 26'h10,      0, 0, 0, 0, 0, 26'h10,      0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_JUMP,   26'h200,     1, 0, 0, 0, 0, 26'h200,     0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, SEL_RETURN, '0,          0, 0, 0, 0, 0, 26'h11,      0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_BRANCH, 26'h40,      0, 0, 0, 0, 0, 26'h40,      0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, SEL_SEQ,    '0,          0, 1, 0, 1, 0, 26'h20, 26'h40, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_JUMP,   26'h123,     1, 0, 1, 0, 0, 26'h40, 26'h40, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, SEL_JUMP,   26'h123,     1, 0, 0, 0, 0, 26'h40, 26'h40, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_BRANCH, 26'h30,      0, 0, 0, 0, 0, 26'h30, 26'h40, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_JUMP,   26'h999,     0, 0, 0, 1, 0, 26'h30, 26'h40, 1, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, SEL_JUMP, 26'h999, 1, 0, 0, 0, 0, 26'h30, 26'h40, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_JUMP,   26'h999,     0, 0, 0, 0, 1, 26'h30, 26'h40, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, SEL_SEQ,    '0,          0, 0, 0, 0, 0, 26'h31, 26'h40, 0, 1, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, SEL_JUMP, AW'(32'h1000 + i * 16), 1, 0, 0, 0, 0,
                       AW'(32'h1000 + i * 16), 26'h40, 0, 0, (i >= 7), (i >= 8), 0));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(1, SEL_RETURN, '0, 0, 0, 0, 0, 0,
                       AW'(32'h1000 + (7 - j) * 16 + 1), 26'h40, 0, (j == 7), 0, 1, 0));
    tbl.push_back(mk(1, SEL_RETURN, '0,          0, 0, 0, 0, 0, 26'h1002, 26'h40, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, SEL_SEQ,    '0,          0, 0, 0, 0, 0, 26'h1003, 26'h40, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, SEL_SEQ,    '0,          0, 0, 0, 1, 0, 26'h1003, 26'h40, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, SEL_SEQ,    '0,          0, 1, 0, 0, 0, 26'h20, 26'h1003, 0, 1, 0, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clock); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_h,
                tbl[i].e_em, tbl[i].e_fu, tbl[i].e_ov, tbl[i].e_un);
    end

    // Randomized run against the model, with a reset between segments
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      pc_reset = 1'b0;
      #1;
      model_reset();
      check_all($sformatf("rrst%0d", r), m_pc, m_epc, m_halt, 1'b1, 1'b0, m_ovf, m_unf);
      @(negedge clock);
      pc_reset = 1'b1;
      for (int c = 0; c < 300; c++) begin
        v = rand_vec();
        drive(v);
        model_step(v);
        @(posedge clock); #1;
        check_all($sformatf("rnd%0d_%0d", r, c), m_pc, m_epc, m_halt,
                  (stk.size() == 0), (stk.size() == DEPTH), m_ovf, m_unf);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
